// File: rtl/fetch_queue_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_queue_stage_if
//  Description : Bus bundle for fetch_queue_stage. It carries the flush sources,
//                the req/ack instruction-memory handshake and the decode-side
//                outputs. Clock and reset are not part of the bundle.
//                The modport named master is the stage's view. The modport
//                named slave is the environment's view (PC control,
//                instruction memory and decode).
//                Optional macro FETCH_PERF_EN adds the perf_* counter outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
interface fetch_queue_stage_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             interrupt;
  logic [XLEN-1:0]  pc_isr;
  logic             redirect_E;
  logic [XLEN-1:0]  pc_redirect_E;
  logic             stall_D;
  logic             imem_req;
  logic [XLEN-1:0]  imem_addr;
  logic             imem_ack;
  logic [XLEN-1:0]  imem_rdata;
  logic             valid_D;
  logic [XLEN-1:0]  instruction_D;
  logic [XLEN-1:0]  pc_D;
  logic [XLEN-1:0]  epc;
  logic [CNT_W-1:0] count;
`ifdef FETCH_PERF_EN
  logic [31:0]      perf_fetched;
  logic [31:0]      perf_flush_lost;
`endif

  modport master (
    input  interrupt, pc_isr, redirect_E, pc_redirect_E, stall_D,
    input  imem_ack, imem_rdata,
    output imem_req, imem_addr,
    output valid_D, instruction_D, pc_D, epc, count
`ifdef FETCH_PERF_EN
    , output perf_fetched, perf_flush_lost
`endif
  );

  modport slave (
    output interrupt, pc_isr, redirect_E, pc_redirect_E, stall_D,
    output imem_ack, imem_rdata,
    input  imem_req, imem_addr,
    input  valid_D, instruction_D, pc_D, epc, count
`ifdef FETCH_PERF_EN
    , input perf_fetched, perf_flush_lost
`endif
  );

endinterface
`default_nettype wire

// File: rtl/fetch_queue_stage.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_queue_stage
//  Description : Instruction fetch stage with a DEPTH-entry prefetch queue of
//                {pc, instruction} pairs. It fetches over a req/ack memory
//                handshake and takes flushes from interrupts, which have
//                priority, and from execute redirects.
//  Ports       : clk            - clock, rising edge
//                rst            - asynchronous reset, active low
//                bus (master)   - interrupt/pc_isr, redirect_E/pc_redirect_E,
//                                 stall_D, imem_req/addr/ack/rdata, valid_D,
//                                 instruction_D, pc_D, epc, count
//                                 (+ perf_fetched, perf_flush_lost)
//  Options     : FETCH_PERF_EN - adds the fetch and flush-loss counters
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue_stage #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter logic [XLEN-1:0] NOP_INSN = 32'h6800_0000
) (
  input  wire logic              clk,
  input  wire logic              rst,
  fetch_queue_stage_if.master    bus
);

  localparam int                 C_PTR_W = $clog2(DEPTH) + 1;
  localparam int                 C_IDX_W = C_PTR_W - 1;
  localparam logic [C_PTR_W-1:0] C_DEPTH = C_PTR_W'(DEPTH);

  logic [XLEN-1:0]    r_fetch_pc;
  logic [C_PTR_W-1:0] r_rd_ptr;
  logic [C_PTR_W-1:0] r_wr_ptr;
  logic [XLEN-1:0]    r_pc_q   [DEPTH];
  logic [XLEN-1:0]    r_insn_q [DEPTH];

  logic [C_PTR_W-1:0] w_count;
  logic               w_valid;
  logic               w_flush;
  logic               w_req;
  logic               w_enq;
  logic               w_deq;
  logic [C_IDX_W-1:0] w_rd_idx;
  logic [C_IDX_W-1:0] w_wr_idx;

  // The pointers carry one extra MSB, so their difference is the occupancy
  // and full (DEPTH) stays distinct from empty (0).
  assign w_count  = r_wr_ptr - r_rd_ptr;
  assign w_valid  = (w_count != '0);
  assign w_flush  = bus.interrupt | bus.redirect_E;
  // A full queue never requests, so no overflow case has to be handled.
  assign w_req    = ~w_flush & (w_count < C_DEPTH);
  assign w_enq    = w_req & bus.imem_ack;
  assign w_deq    = w_valid & ~bus.stall_D & ~w_flush;
  assign w_rd_idx = r_rd_ptr[C_IDX_W-1:0];
  assign w_wr_idx = r_wr_ptr[C_IDX_W-1:0];

  // The decode-side outputs come only from registered state.
  assign bus.imem_req      = w_req;
  assign bus.imem_addr     = r_fetch_pc;
  assign bus.valid_D       = w_valid;
  assign bus.instruction_D = w_valid ? r_insn_q[w_rd_idx] : NOP_INSN;
  assign bus.pc_D          = w_valid ? r_pc_q[w_rd_idx]   : '0;
  assign bus.epc           = w_valid ? r_pc_q[w_rd_idx]   : r_fetch_pc;
  assign bus.count         = w_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fetch_pc <= RESET_PC;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
    end else if (w_flush) begin
      // Any ack in this cycle is dropped, because w_req is low.
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_fetch_pc <= bus.interrupt ? bus.pc_isr : bus.pc_redirect_E;
    end else begin
      if (w_enq) begin
        r_wr_ptr   <= r_wr_ptr + C_PTR_W'(1);
        r_fetch_pc <= r_fetch_pc + XLEN'(4);
      end
      if (w_deq) begin
        r_rd_ptr <= r_rd_ptr + C_PTR_W'(1);
      end
    end
  end

  // Queue storage needs no reset; the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_pc_q[w_wr_idx]   <= r_fetch_pc;
      r_insn_q[w_wr_idx] <= bus.imem_rdata;
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] r_perf_fetched;
  logic [31:0] r_perf_flush_lost;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_perf_fetched    <= '0;
      r_perf_flush_lost <= '0;
    end else begin
      if (w_enq) begin
        r_perf_fetched <= r_perf_fetched + 32'd1;
      end
      // The queued entries are lost, plus the instruction acked in the flush cycle.
      if (w_flush) begin
        r_perf_flush_lost <= r_perf_flush_lost + 32'(w_count) + 32'(bus.imem_ack);
      end
    end
  end

  assign bus.perf_fetched    = r_perf_fetched;
  assign bus.perf_flush_lost = r_perf_flush_lost;
`endif

endmodule
`default_nettype wire
